postbox_bridge: RTL and testbench



---
 rtl/postbox_pkg.sv | 19 +
 rtl/postbox_sync_fifo.sv | 66 ++++++
 rtl/postbox_bridge.sv | 136 +++++++++++++
 tb/tb_postbox_bridge.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/postbox_pkg.sv
// Shared types and defaults for the POST engine byte bridge.
package postbox_pkg;

    localparam int DEFAULT_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_ACK  = 2'd1,
        RX_WAIT = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_WAIT  = 2'd2,
        TX_HOLD  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/postbox_sync_fifo.sv
// First-word fall-through circular FIFO; pointers carry one extra wrap bit.
module postbox_sync_fifo
    import postbox_pkg::*;
#(
    parameter int  WIDTH   = 8,
    parameter int  DEPTH   = DEFAULT_FIFO_DEPTH,
    localparam int AW      = $clog2(DEPTH),
    localparam int LEVEL_W = AW + 1
) (
    input  logic               refclk,
    input  logic               reset_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    localparam logic [AW:0] PTR_INC = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    // Head is forced to zero when empty so the output never shows stale storage.
    assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_INC;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_INC;
        end
    end

    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge refclk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/postbox_bridge.sv
// Bridges the POST engine byte handshake to host valid/ready streams,
// buffering each direction in its own FIFO.
module postbox_bridge
    import postbox_pkg::*;
#(
    parameter int  FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               refclk,
    input  logic               reset_n,
    input  logic [7:0]         post_rxout,
    input  logic               post_rxfull,
    output logic               post_rxreset,
    output logic [7:0]         post_txin,
    input  logic               post_txempty,
    output logic               post_txstart,
    output logic [7:0]         host_rx_data,
    output logic               host_rx_valid,
    input  logic               host_rx_ready,
    input  logic [7:0]         host_tx_data,
    input  logic               host_tx_valid,
    output logic               host_tx_ready,
    input  logic               flush,
    output logic [LEVEL_W-1:0] rx_level,
    output logic [LEVEL_W-1:0] tx_level
);

    rx_state_t  rx_state_q, rx_state_d;
    tx_state_t  tx_state_q, tx_state_d;
    logic [7:0] post_txin_q, post_txin_d;
    logic       rx_push, rx_full, rx_empty;
    logic       tx_pop, tx_full, tx_empty;
    logic [7:0] tx_dout;

    postbox_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .refclk (refclk),
        .reset_n(reset_n),
        .push   (rx_push),
        .pop    (host_rx_ready),
        .flush  (flush),
        .din    (post_rxout),
        .dout   (host_rx_data),
        .full   (rx_full),
        .empty  (rx_empty),
        .level  (rx_level)
    );

    postbox_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .refclk (refclk),
        .reset_n(reset_n),
        .push   (host_tx_valid),
        .pop    (tx_pop),
        .flush  (flush),
        .din    (host_tx_data),
        .dout   (tx_dout),
        .full   (tx_full),
        .empty  (tx_empty),
        .level  (tx_level)
    );

    assign host_rx_valid = !rx_empty;
    assign host_tx_ready = !tx_full;
    assign post_txin     = post_txin_q;

    // RX_WAIT keeps the same byte from being pushed twice while rxfull is still high.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_push      = 1'b0;
        post_rxreset = 1'b0;
        if (flush) begin
            rx_state_d = RX_IDLE;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (post_rxfull && !rx_full) begin
                        rx_push    = 1'b1;
                        rx_state_d = RX_ACK;
                    end
                end
                RX_ACK: begin
                    post_rxreset = 1'b1;
                    rx_state_d   = RX_WAIT;
                end
                RX_WAIT: begin
                    if (!post_rxfull) rx_state_d = RX_IDLE;
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    // txin is only reloaded on a pop; the engine samples it later, at shift start.
    always_comb begin
        tx_state_d   = tx_state_q;
        post_txin_d  = post_txin_q;
        tx_pop       = 1'b0;
        post_txstart = 1'b0;
        if (flush) begin
            tx_state_d = TX_IDLE;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (!tx_empty && post_txempty) begin
                        tx_pop      = 1'b1;
                        post_txin_d = tx_dout;
                        tx_state_d  = TX_START;
                    end
                end
                TX_START: begin
                    post_txstart = 1'b1;
                    tx_state_d   = TX_WAIT;
                end
                TX_WAIT: begin
                    if (!post_txempty) tx_state_d = TX_HOLD;
                end
                TX_HOLD: begin
                    if (post_txempty) tx_state_d = TX_IDLE;
                end
                default: tx_state_d = TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q  <= RX_IDLE;
            tx_state_q  <= TX_IDLE;
            post_txin_q <= '0;
        end else begin
            rx_state_q  <= rx_state_d;
            tx_state_q  <= tx_state_d;
            post_txin_q <= post_txin_d;
        end
    end

endmodule

// File: tb/tb_postbox_bridge.sv
// Scoreboard bench for postbox_bridge: engine and host models drive random
// and directed traffic, expected bytes flow through queues to the monitors.
module tb_postbox_bridge;

    localparam int DEPTH   = 16;
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic               refclk;
    logic               reset_n;
    logic [7:0]         post_rxout;
    logic               post_rxfull;
    logic               post_rxreset;
    logic [7:0]         post_txin;
    logic               post_txempty;
    logic               post_txstart;
    logic [7:0]         host_rx_data;
    logic               host_rx_valid;
    logic               host_rx_ready;
    logic [7:0]         host_tx_data;
    logic               host_tx_valid;
    logic               host_tx_ready;
    logic               flush;
    logic [LEVEL_W-1:0] rx_level;
    logic [LEVEL_W-1:0] tx_level;

    postbox_bridge #(.FIFO_DEPTH(DEPTH)) dut (
        .refclk       (refclk),
        .reset_n      (reset_n),
        .post_rxout   (post_rxout),
        .post_rxfull  (post_rxfull),
        .post_rxreset (post_rxreset),
        .post_txin    (post_txin),
        .post_txempty (post_txempty),
        .post_txstart (post_txstart),
        .host_rx_data (host_rx_data),
        .host_rx_valid(host_rx_valid),
        .host_rx_ready(host_rx_ready),
        .host_tx_data (host_tx_data),
        .host_tx_valid(host_tx_valid),
        .host_tx_ready(host_tx_ready),
        .flush        (flush),
        .rx_level     (rx_level),
        .tx_level     (tx_level)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard queues: bytes the target still has to deliver, bytes the host
    // should see, bytes the engine should be offered.
    logic [7:0] rx_src[$];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];

    // Engine model knobs and counters.
    bit         rx_gaps      = 0;
    bit         rx_drop      = 0;
    bit         tx_stall     = 0;
    bit         rand_rdy     = 0;
    int         shift_cycles = 0;
    int         tx_phase     = 0;
    int         tx_cnt       = 0;
    logic [7:0] tx_cap       = '0;
    int         rx_ack_cnt   = 0;
    int         tx_start_cnt = 0;
    int         rxreset_cnt  = 0;

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Target-side engine: presents bytes, drops rxfull the cycle after the ack.
    always begin
        @(posedge refclk); #1;
        if (rx_drop) begin
            post_rxfull = 1'b0;
            rx_drop     = 0;
        end else if (!post_rxfull && rx_src.size() > 0 &&
                     (!rx_gaps || $urandom_range(0, 2) == 0)) begin
            post_rxfull = 1'b1;
            post_rxout  = rx_src[0];
        end
        #1;
        if (reset_n && post_rxreset) begin
            rx_ack_cnt++;
            check("rx_ack_while_rxfull", post_rxfull, 1);
            if (post_rxfull) begin
                exp_rx.push_back(post_rxout);
                void'(rx_src.pop_front());
                rx_drop = 1;
            end
        end
    end

    // Host-side engine: latches after txstart, shifts, then reports empty again.
    always begin
        @(posedge refclk); #1;
        case (tx_phase)
            0: post_txempty = !tx_stall;
            1: begin
                tx_cnt--;
                if (tx_cnt <= 0) begin
                    post_txempty = 1'b0;
                    tx_phase     = 2;
                    tx_cnt       = (shift_cycles > 0) ? shift_cycles : int'($urandom_range(1, 4));
                end
            end
            default: begin
                tx_cnt--;
                if (tx_cnt <= 0) begin
                    check("txin_held_until_shift", post_txin, tx_cap);
                    post_txempty = 1'b1;
                    tx_phase     = 0;
                end
            end
        endcase
        #1;
        if (reset_n && post_txstart) begin
            tx_start_cnt++;
            check("txstart_engine_ready", (tx_phase == 0) && post_txempty, 1);
            check("tx_exp_available", exp_tx.size() != 0, 1);
            if (exp_tx.size() != 0) check("tx_data_order", post_txin, exp_tx.pop_front());
            tx_cap   = post_txin;
            tx_phase = 1;
            tx_cnt   = $urandom_range(1, 2);
        end
    end

    always begin
        @(posedge refclk); #1;
        if (rand_rdy) host_rx_ready = ($urandom_range(0, 2) != 0);
    end

    // RX monitor: every host pop is compared with the scoreboard head.
    always @(negedge refclk) begin
        if (post_rxreset) rxreset_cnt++;
        if (reset_n && !flush && host_rx_valid && host_rx_ready) begin
            check("rx_pop_expected", exp_rx.size() != 0, 1);
            if (exp_rx.size() != 0) check("rx_data_order", host_rx_data, exp_rx.pop_front());
        end
    end

    task automatic host_send(input logic [7:0] b);
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge refclk); #1;
            host_tx_valid = 1'b1;
            host_tx_data  = b;
            if (host_tx_ready && !flush) begin
                ok = 1;
                exp_tx.push_back(b);
            end
        end
        @(posedge refclk); #1;
        host_tx_valid = 1'b0;
        check("host_send_accepted", ok, 1);
    endtask

    task automatic set_ready_at_edge(input logic v);
        @(posedge refclk); #1;
        host_rx_ready = v;
    endtask

    initial begin : global_timeout
        #600000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin : main
        int t;
        int base;
        int base2;
        logic [7:0] txin_b;

        reset_n       = 1'b0;
        post_rxout    = '0;
        post_rxfull   = 1'b0;
        post_txempty  = 1'b1;
        host_rx_ready = 1'b0;
        host_tx_data  = '0;
        host_tx_valid = 1'b0;
        flush         = 1'b0;
        repeat (3) @(negedge refclk);

        // Reset state
        check("rst_rxreset", post_rxreset, 0);
        check("rst_txstart", post_txstart, 0);
        check("rst_txin", post_txin, 0);
        check("rst_rx_valid", host_rx_valid, 0);
        check("rst_rx_data", host_rx_data, 0);
        check("rst_tx_ready", host_tx_ready, 1);
        check("rst_levels", {rx_level, tx_level}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge refclk);

        // Single RX byte, exactly one ack
        base = rxreset_cnt;
        rx_src.push_back(8'hA5);
        t = 0;
        while (rx_level != 1 && t < 100) begin @(negedge refclk); t++; end
        repeat (6) @(negedge refclk);
        check("t1_rxreset_pulses", rxreset_cnt - base, 1);
        check("t1_rx_level", rx_level, 1);
        check("t1_rx_data", host_rx_data, 8'hA5);
        set_ready_at_edge(1'b1);
        set_ready_at_edge(1'b0);
        @(negedge refclk);
        check("t1_rx_level_after_pop", rx_level, 0);

        // Two TX bytes
        base = tx_start_cnt;
        host_send(8'h3C);
        host_send(8'h81);
        t = 0;
        while (!(tx_start_cnt == base + 2 && tx_phase == 0 && tx_level == 0) && t < 200) begin
            @(negedge refclk); t++;
        end
        check("t2_txstart_pulses", tx_start_cnt - base, 2);
        check("t2_tx_level", tx_level, 0);
        check("t2_txin_last", post_txin, 8'h81);

        // RX full: 17 bytes with host stalled
        base = rx_ack_cnt;
        for (int i = 0; i < 17; i++) rx_src.push_back(8'(8'h10 + i));
        t = 0;
        while (rx_level != LEVEL_W'(DEPTH) && t < 300) begin @(negedge refclk); t++; end
        repeat (4) @(negedge refclk);
        base2 = rxreset_cnt;
        repeat (10) @(negedge refclk);
        check("t3_rx_level_full", rx_level, DEPTH);
        check("t3_tx_ready_unaffected", host_tx_ready, 1);
        check("t3_17th_unacked_rxfull", post_rxfull, 1);
        check("t3_acks_16", rx_ack_cnt - base, 16);
        check("t3_no_rxreset_while_full", rxreset_cnt - base2, 0);
        set_ready_at_edge(1'b1);
        set_ready_at_edge(1'b0);
        repeat (6) @(negedge refclk);
        check("t3_acks_17", rx_ack_cnt - base, 17);
        check("t3_rx_level_refilled", rx_level, DEPTH);
        set_ready_at_edge(1'b1);
        t = 0;
        while ((rx_level != 0 || rx_src.size() != 0) && t < 300) begin @(negedge refclk); t++; end
        set_ready_at_edge(1'b0);
        @(negedge refclk);
        check("t3_drained", {exp_rx.size() == 0, rx_level}, {1'b1, LEVEL_W'(0)});

        // TX full with the engine stalled, then drain in order
        tx_stall = 1;
        repeat (3) @(negedge refclk);
        base = tx_start_cnt;
        for (int i = 0; i < 16; i++) host_send(8'(i));
        @(negedge refclk);
        check("t4_tx_level_full", tx_level, DEPTH);
        check("t4_tx_ready_low", host_tx_ready, 0);
        @(posedge refclk); #1;
        host_tx_valid = 1'b1;
        host_tx_data  = 8'hEE;
        check("t4_17th_push_not_ready", host_tx_ready, 0);
        @(posedge refclk); #1;
        host_tx_valid = 1'b0;
        @(negedge refclk);
        check("t4_17th_ignored", tx_level, DEPTH);
        tx_stall = 0;
        t = 0;
        while (!(tx_start_cnt == base + 16 && tx_phase == 0 && tx_level == 0) && t < 2000) begin
            @(negedge refclk); t++;
        end
        check("t4_drained_16", tx_start_cnt - base, 16);
        check("t4_tx_exp_empty", exp_tx.size(), 0);

        // Simultaneous pop and push at level 3
        for (int i = 0; i < 3; i++) rx_src.push_back(8'(8'hC0 + i));
        t = 0;
        while (!(rx_level == 3 && !post_rxfull) && t < 100) begin @(negedge refclk); t++; end
        repeat (4) @(negedge refclk);
        check("t5_level_3", rx_level, 3);
        rx_src.push_back(8'hC3);
        set_ready_at_edge(1'b1);
        set_ready_at_edge(1'b0);
        @(negedge refclk);
        check("t5_level_unchanged", rx_level, 3);
        check("t5_ack_in_progress", post_rxreset, 1);
        set_ready_at_edge(1'b1);
        t = 0;
        while ((rx_level != 0 || rx_src.size() != 0) && t < 100) begin @(negedge refclk); t++; end
        set_ready_at_edge(1'b0);
        @(negedge refclk);
        check("t5_order_drained", exp_rx.size(), 0);

        // Flush while TX_HOLD with 5 queued
        rx_src.push_back(8'h5A);
        rx_src.push_back(8'h5B);
        shift_cycles = 30;
        for (int i = 0; i < 6; i++) host_send(8'(8'h40 + i));
        t = 0;
        while (!(tx_level == 5 && tx_phase == 2 && rx_level == 2 && !post_rxfull) && t < 100) begin
            @(negedge refclk); t++;
        end
        repeat (2) @(negedge refclk);
        check("t6_pre_tx_level", tx_level, 5);
        base = tx_start_cnt;
        @(posedge refclk); #1;
        flush  = 1'b1;
        txin_b = post_txin;
        exp_tx.delete();
        exp_rx.delete();
        @(negedge refclk);
        check("t6_flush_txstart_low", post_txstart, 0);
        check("t6_flush_rxreset_low", post_rxreset, 0);
        @(posedge refclk); #1;
        flush = 1'b0;
        @(negedge refclk);
        check("t6_levels_zero", {rx_level, tx_level}, 0);
        check("t6_txin_kept", post_txin, txin_b);
        check("t6_txin_is_byte", txin_b, 8'h40);
        t = 0;
        while (tx_phase != 0 && t < 100) begin @(negedge refclk); t++; end
        repeat (10) @(negedge refclk);
        check("t6_no_resend", tx_start_cnt - base, 0);
        shift_cycles = 0;
        host_send(8'h99);
        t = 0;
        while (!(tx_start_cnt == base + 1 && tx_phase == 0) && t < 100) begin @(negedge refclk); t++; end
        check("t6_tx_fsm_idle_after_flush", tx_start_cnt - base, 1);
        check("t6_txin_new", post_txin, 8'h99);

        // Reset pulse mid-RX_ACK
        rx_src.push_back(8'h11);
        t = 0;
        while (!(rx_level == 1 && !post_rxfull) && t < 100) begin @(negedge refclk); t++; end
        repeat (3) @(negedge refclk);
        rx_src.push_back(8'h77);
        t = 0;
        while (!post_rxreset && t < 100) begin @(negedge refclk); t++; end
        check("t7_reached_rx_ack", post_rxreset, 1);
        reset_n = 1'b0;
        exp_rx.delete();
        exp_tx.delete();
        #1;
        check("t7_rst_rxreset", post_rxreset, 0);
        check("t7_rst_txin", post_txin, 0);
        check("t7_rst_levels", {rx_level, tx_level}, 0);
        @(negedge refclk);
        #2 reset_n = 1'b1;
        repeat (6) @(negedge refclk);
        check("t7_levels_after", {rx_level, tx_level}, 0);
        check("t7_txin_after", post_txin, 0);
        check("t7_tx_ready", host_tx_ready, 1);

        // Randomized traffic in both directions
        rx_gaps  = 1;
        rand_rdy = 1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 6)) @(negedge refclk);
                    rx_src.push_back(8'($urandom));
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 4)) @(negedge refclk);
                    host_send(8'($urandom));
                end
            end
        join
        t = 0;
        while (!(rx_src.size() == 0 && exp_rx.size() == 0 && rx_level == 0 &&
                 exp_tx.size() == 0 && tx_level == 0 && tx_phase == 0) && t < 5000) begin
            @(negedge refclk); t++;
        end
        rand_rdy = 0;
        @(negedge refclk);
        host_rx_ready = 1'b0;
        check("rand_rx_drained", exp_rx.size() + rx_src.size(), 0);
        check("rand_tx_drained", exp_tx.size(), 0);
        check("rand_levels_zero", {rx_level, tx_level}, 0);

        repeat (3) @(negedge refclk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
